// File: rtl/galvani_pkg.sv
// Shared frame layout, byte positions and parser state type for the NI
// command receive path.
package galvani_pkg;

  localparam int FRAME_LEN = 8;
  localparam int B_CTRL    = 1;
  localparam int B_BIAS    = 2;
  localparam int B_AMP0    = 3;
  localparam int B_CSUM    = FRAME_LEN - 1;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef struct packed {
    logic            mode;
    logic            bias_sel;
    logic [6:0]      bias_amp;
    logic [4:0]      addr;
    logic [3:0][7:0] amp;
  } frame_t;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    BODY  = 2'd1,
    CHECK = 2'd2
  } prs_state_t;

endpackage

// File: rtl/frame_fifo.sv
// First-word-fall-through frame FIFO. When empty, rdata keeps showing the
// most recently popped frame instead of a stale storage slot.
module frame_fifo
  import galvani_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    push,
  input  frame_t                  wdata,
  input  logic                    pop,
  output frame_t                  rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  frame_t        mem [DEPTH];
  frame_t        last_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // a push into a full FIFO is dropped even when a pop frees a slot this cycle
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      last_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ni_frame_rx.sv
// NI bus front end: synchronises the NI byte bus, parses checksummed 8-byte
// command frames and queues good frames for the command-generation stage.
//
// state | meaning
// HUNT  | waiting for SYNC_BYTE
// BODY  | collecting b1..b6 into the shadow frame, accumulating XOR
// CHECK | waiting for b7 to compare against the accumulated XOR
module ni_frame_rx
  import galvani_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter int         TIMEOUT   = 255,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       NI_CLK,
  input  logic       NI_DATA_READY,
  input  logic [7:0] NI_DIGITAL_IN,
  input  logic       FRAME_READY,
  output logic       FRAME_VALID,
  output logic       MODE,
  output logic       BIAS_SEL,
  output logic [6:0] BIAS_AMP,
  output logic [4:0] ADDR,
  output logic [7:0] AMP0,
  output logic [7:0] AMP1,
  output logic [7:0] AMP2,
  output logic [7:0] AMP3,
  output logic       FIFO_FULL,
  output logic [7:0] CSUM_ERR_CNT,
  output logic [7:0] OVF_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    clk_sync;
  logic [1:0]    rdy_sync;
  logic [7:0]    dat_s1;
  logic [7:0]    dat_s2;
  logic          strobe;

  prs_state_t    state, state_nxt;
  logic [2:0]    idx;
  logic [7:0]    csum;
  logic [TW-1:0] tmr;
  frame_t        shadow;
  logic          push_nxt, push_q, err_inc;

  frame_t        head;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;

  assign strobe = clk_sync[1] & ~clk_sync[2] & rdy_sync[1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      clk_sync <= '0;
      rdy_sync <= '0;
      dat_s1   <= '0;
      dat_s2   <= '0;
    end else begin
      clk_sync <= {clk_sync[1:0], NI_CLK};
      rdy_sync <= {rdy_sync[0], NI_DATA_READY};
      dat_s1   <= NI_DIGITAL_IN;
      dat_s2   <= dat_s1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= HUNT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push_nxt  = 1'b0;
    err_inc   = 1'b0;
    case (state)
      HUNT: if (strobe && dat_s2 == SYNC_BYTE) state_nxt = BODY;
      BODY: begin
        if (strobe) begin
          if (idx == 3'(B_CSUM - 1)) state_nxt = CHECK;
        end else if (tmr == '0) begin
          state_nxt = HUNT;
          err_inc   = 1'b1;
        end
      end
      CHECK: begin
        if (strobe) begin
          state_nxt = HUNT;
          if (dat_s2 == csum) push_nxt = 1'b1;
          else                err_inc  = 1'b1;
        end else if (tmr == '0) begin
          state_nxt = HUNT;
          err_inc   = 1'b1;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // timeout is a down-counter reloaded on every strobe and held while hunting
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idx          <= '0;
      csum         <= '0;
      tmr          <= TW'(TIMEOUT);
      shadow       <= '0;
      push_q       <= 1'b0;
      CSUM_ERR_CNT <= '0;
    end else begin
      push_q <= push_nxt;
      if (err_inc && CSUM_ERR_CNT != 8'hFF) CSUM_ERR_CNT <= CSUM_ERR_CNT + 8'd1;
      if (strobe || state == HUNT) tmr <= TW'(TIMEOUT);
      else if (tmr != '0)          tmr <= tmr - TW'(1);
      if (strobe && state == HUNT) begin
        idx  <= 3'(B_CTRL);
        csum <= '0;
      end else if (strobe && state == BODY) begin
        idx  <= idx + 3'd1;
        csum <= csum ^ dat_s2;
        case (idx)
          3'(B_CTRL): begin
            shadow.mode     <= dat_s2[7];
            shadow.bias_sel <= dat_s2[6];
            shadow.addr     <= dat_s2[4:0];
          end
          3'(B_BIAS): shadow.bias_amp <= dat_s2[6:0];
          default:    shadow.amp[2'(idx - 3'(B_AMP0))] <= dat_s2;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                           OVF_CNT <= '0;
    else if (push_q && fifo_full && OVF_CNT != 8'hFF) OVF_CNT <= OVF_CNT + 8'd1;
  end

  frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push_q),
    .wdata (shadow),
    .pop   (FRAME_VALID & FRAME_READY),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign FRAME_VALID = ~fifo_empty;
  assign FIFO_FULL   = (fifo_count == (AW+1)'(DEPTH));
  assign MODE        = head.mode;
  assign BIAS_SEL    = head.bias_sel;
  assign BIAS_AMP    = head.bias_amp;
  assign ADDR        = head.addr;
  assign AMP0        = head.amp[0];
  assign AMP1        = head.amp[1];
  assign AMP2        = head.amp[2];
  assign AMP3        = head.amp[3];

endmodule

// File: tb/tb_ni_frame_rx.sv
// Directed bench for ni_frame_rx: drives NI byte transfers on the falling
// CLK edge and checks decoded frames, latency, error and overflow counters.
module tb_ni_frame_rx;

  logic       CLK;
  logic       RST;
  logic       NI_CLK;
  logic       NI_DATA_READY;
  logic [7:0] NI_DIGITAL_IN;
  logic       FRAME_READY;
  logic       FRAME_VALID;
  logic       MODE;
  logic       BIAS_SEL;
  logic [6:0] BIAS_AMP;
  logic [4:0] ADDR;
  logic [7:0] AMP0, AMP1, AMP2, AMP3;
  logic       FIFO_FULL;
  logic [7:0] CSUM_ERR_CNT;
  logic [7:0] OVF_CNT;

  int vectors = 0;
  int errors  = 0;

  logic [45:0] pops [$];

  localparam logic [45:0] SINGLE = {1'b1, 1'b0, 7'h40, 5'h03, 8'h10, 8'h00, 8'hFF, 8'h01};

  ni_frame_rx dut (
    .CLK           (CLK),
    .RST           (RST),
    .NI_CLK        (NI_CLK),
    .NI_DATA_READY (NI_DATA_READY),
    .NI_DIGITAL_IN (NI_DIGITAL_IN),
    .FRAME_READY   (FRAME_READY),
    .FRAME_VALID   (FRAME_VALID),
    .MODE          (MODE),
    .BIAS_SEL      (BIAS_SEL),
    .BIAS_AMP      (BIAS_AMP),
    .ADDR          (ADDR),
    .AMP0          (AMP0),
    .AMP1          (AMP1),
    .AMP2          (AMP2),
    .AMP3          (AMP3),
    .FIFO_FULL     (FIFO_FULL),
    .CSUM_ERR_CNT  (CSUM_ERR_CNT),
    .OVF_CNT       (OVF_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // record every frame the downstream side actually accepts
  always @(negedge CLK) begin
    #1;
    if (FRAME_VALID && FRAME_READY)
      pops.push_back({MODE, BIAS_SEL, BIAS_AMP, ADDR, AMP0, AMP1, AMP2, AMP3});
  end

  function automatic logic [45:0] exp_of(input logic [7:0] b1, b2, b3, b4, b5, b6);
    return {b1[7], b1[6], b2[6:0], b1[4:0], b3, b4, b5, b6};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    NI_DIGITAL_IN = b;
    NI_DATA_READY = 1'b1;
    repeat (4) @(negedge CLK);
    NI_CLK = 1'b1;
    repeat (4) @(negedge CLK);
    NI_CLK = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] b1, b2, b3, b4, b5, b6, input logic bad);
    send_byte(8'hA5);
    send_byte(b1); send_byte(b2); send_byte(b3);
    send_byte(b4); send_byte(b5); send_byte(b6);
    send_byte(b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6 ^ {7'd0, bad});
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({FRAME_VALID, MODE, BIAS_SEL, BIAS_AMP, ADDR, AMP0, AMP1, AMP2, AMP3,
         FIFO_FULL, CSUM_ERR_CNT, OVF_CNT} !== 64'h0)
      $display("FAIL reset_outputs: got valid=%b full=%b err=%h ovf=%h, required all zero",
               FRAME_VALID, FIFO_FULL, CSUM_ERR_CNT, OVF_CNT);
    if ({FRAME_VALID, MODE, BIAS_SEL, BIAS_AMP, ADDR, AMP0, AMP1, AMP2, AMP3,
         FIFO_FULL, CSUM_ERR_CNT, OVF_CNT} !== 64'h0) errors++;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_single_frame;
    int first = -1;
    int high  = 0;
    pops.delete();
    send_byte(8'hA5); send_byte(8'h83); send_byte(8'h40); send_byte(8'h10);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h01);
    NI_DIGITAL_IN = 8'h2D;
    repeat (4) @(negedge CLK);
    NI_CLK = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (FRAME_VALID) begin
        high++;
        if (first < 0) first = k;
      end
      if (k == 4) NI_CLK = 1'b0;
    end
    vectors++;
    if (first !== 4) begin
      errors++;
      $display("FAIL single_latency: got first valid at edge %0d, required 4", first);
    end
    vectors++;
    if (high !== 1) begin
      errors++;
      $display("FAIL single_pulse_width: got %0d valid cycles, required 1", high);
    end
    vectors++;
    if (pops.size() !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d frames, required 1", pops.size());
    end
    vectors++;
    if (pops[0] !== SINGLE) begin
      errors++;
      $display("FAIL single_fields: got %h, required %h", pops[0], SINGLE);
    end
    vectors++;
    if ({MODE, BIAS_SEL, BIAS_AMP, ADDR, AMP0, AMP1, AMP2, AMP3} !== SINGLE) begin
      errors++;
      $display("FAIL single_hold: got %h, required %h",
               {MODE, BIAS_SEL, BIAS_AMP, ADDR, AMP0, AMP1, AMP2, AMP3}, SINGLE);
    end
    vectors++;
    if (CSUM_ERR_CNT !== 8'h00) begin
      errors++;
      $display("FAIL single_err_cnt: got %h, required 00", CSUM_ERR_CNT);
    end
  endtask

  task automatic test_garbage;
    logic [45:0] exp_f = {1'b1, 1'b1, 7'h7F, 5'h07, 8'h01, 8'h02, 8'h03, 8'h04};
    pops.delete();
    send_byte(8'h00);
    send_byte(8'h12);
    send_frame(8'hE7, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    vectors++;
    if (pops.size() !== 1) begin
      errors++;
      $display("FAIL garbage_count: got %0d frames, required 1", pops.size());
    end
    vectors++;
    if (pops[0] !== exp_f) begin
      errors++;
      $display("FAIL garbage_fields: got %h, required %h", pops[0], exp_f);
    end
    vectors++;
    if (CSUM_ERR_CNT !== 8'h00) begin
      errors++;
      $display("FAIL garbage_err_cnt: got %h, required 00", CSUM_ERR_CNT);
    end
  endtask

  task automatic test_bad_csum;
    logic [45:0] exp_f = {1'b0, 1'b0, 7'h05, 5'h02, 8'hAA, 8'h55, 8'h0F, 8'hF0};
    pops.delete();
    send_frame(8'h83, 8'h40, 8'h10, 8'h00, 8'hFF, 8'h01, 1'b1);
    vectors++;
    if (pops.size() !== 0) begin
      errors++;
      $display("FAIL bad_csum_dropped: got %0d frames, required 0", pops.size());
    end
    vectors++;
    if (CSUM_ERR_CNT !== 8'h01) begin
      errors++;
      $display("FAIL bad_csum_err_cnt: got %h, required 01", CSUM_ERR_CNT);
    end
    send_frame(8'h02, 8'h05, 8'hAA, 8'h55, 8'h0F, 8'hF0, 1'b0);
    vectors++;
    if (pops.size() !== 1 || pops[0] !== exp_f) begin
      errors++;
      $display("FAIL bad_csum_recover: got %0d frames head %h, required 1 frame %h",
               pops.size(), pops[0], exp_f);
    end
  endtask

  task automatic test_timeout;
    pops.delete();
    send_byte(8'hA5); send_byte(8'h83); send_byte(8'h40);
    send_byte(8'h10); send_byte(8'h00);
    repeat (300) @(negedge CLK);
    vectors++;
    if (CSUM_ERR_CNT !== 8'h02) begin
      errors++;
      $display("FAIL timeout_err_cnt: got %h, required 02", CSUM_ERR_CNT);
    end
    send_frame(8'h83, 8'h40, 8'h10, 8'h00, 8'hFF, 8'h01, 1'b0);
    vectors++;
    if (pops.size() !== 1 || pops[0] !== SINGLE) begin
      errors++;
      $display("FAIL timeout_recover: got %0d frames head %h, required 1 frame %h",
               pops.size(), pops[0], SINGLE);
    end
    vectors++;
    if (CSUM_ERR_CNT !== 8'h02) begin
      errors++;
      $display("FAIL timeout_err_stable: got %h, required 02", CSUM_ERR_CNT);
    end
  endtask

  task automatic test_back_pressure;
    logic [45:0] exp_q [$];
    logic [7:0]  k8;
    pops.delete();
    FRAME_READY = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      k8 = 8'(k);
      send_frame(8'h40 | k8, 8'(8 * k), k8, 8'hF0 | k8, 8'(17 * k), 8'hC0, 1'b0);
      exp_q.push_back(exp_of(8'h40 | k8, 8'(8 * k), k8, 8'hF0 | k8, 8'(17 * k), 8'hC0));
      if (k == 4) begin
        vectors++;
        if (FIFO_FULL !== 1'b1 || OVF_CNT !== 8'h00) begin
          errors++;
          $display("FAIL bp_full_after_4: got full=%b ovf=%h, required full=1 ovf=00",
                   FIFO_FULL, OVF_CNT);
        end
        vectors++;
        if (FRAME_VALID !== 1'b1 ||
            {MODE, BIAS_SEL, BIAS_AMP, ADDR, AMP0, AMP1, AMP2, AMP3} !== exp_q[0]) begin
          errors++;
          $display("FAIL bp_head: got valid=%b head=%h, required valid=1 head=%h", FRAME_VALID,
                   {MODE, BIAS_SEL, BIAS_AMP, ADDR, AMP0, AMP1, AMP2, AMP3}, exp_q[0]);
        end
      end
    end
    vectors++;
    if (OVF_CNT !== 8'h01 || FIFO_FULL !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow: got ovf=%h full=%b, required ovf=01 full=1", OVF_CNT, FIFO_FULL);
    end
    FRAME_READY = 1'b1;
    repeat (10) @(negedge CLK);
    vectors++;
    if (pops.size() !== 4) begin
      errors++;
      $display("FAIL bp_drain_count: got %0d frames, required 4", pops.size());
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (pops[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_order_%0d: got %h, required %h", i, pops[i], exp_q[i]);
      end
    end
    vectors++;
    if (FIFO_FULL !== 1'b0 || FRAME_VALID !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty_after_drain: got full=%b valid=%b, required 0 0",
               FIFO_FULL, FRAME_VALID);
    end
  endtask

  task automatic test_reset_mid_frame;
    pops.delete();
    send_byte(8'hA5); send_byte(8'h83); send_byte(8'h40); send_byte(8'h10);
    RST = 1'b0;
    #1;
    vectors++;
    if ({FRAME_VALID, MODE, BIAS_SEL, BIAS_AMP, ADDR, AMP0, AMP1, AMP2, AMP3,
         FIFO_FULL, CSUM_ERR_CNT, OVF_CNT} !== 64'h0) begin
      errors++;
      $display("FAIL reset_async: got head=%h err=%h ovf=%h, required all zero",
               {MODE, BIAS_SEL, BIAS_AMP, ADDR, AMP0, AMP1, AMP2, AMP3}, CSUM_ERR_CNT, OVF_CNT);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    send_frame(8'h83, 8'h40, 8'h10, 8'h00, 8'hFF, 8'h01, 1'b0);
    vectors++;
    if (pops.size() !== 1 || pops[0] !== SINGLE) begin
      errors++;
      $display("FAIL reset_recover: got %0d frames head %h, required 1 frame %h",
               pops.size(), pops[0], SINGLE);
    end
    vectors++;
    if (CSUM_ERR_CNT !== 8'h00 || OVF_CNT !== 8'h00) begin
      errors++;
      $display("FAIL reset_counters: got err=%h ovf=%h, required 00 00", CSUM_ERR_CNT, OVF_CNT);
    end
  endtask

  initial begin
    RST           = 1'b1;
    NI_CLK        = 1'b0;
    NI_DATA_READY = 1'b0;
    NI_DIGITAL_IN = 8'h00;
    FRAME_READY   = 1'b1;
    test_reset();
    test_single_frame();
    test_garbage();
    test_bad_csum();
    test_timeout();
    test_back_pressure();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ni_frame_rx.md
Name: ni_frame_rx

Overview:
- Upstream front end of the stimulator command path.
- Oversamples the NI digital bus (NI_CLK, NI_DATA_READY, 8-bit data) in the divided system clock domain and parses 8-byte command frames.
- Checks the XOR checksum of each frame and buffers good frames in a small frame FIFO.
- Presents decoded fields (MODE, BIAS_SEL, BIAS_AMP, ADDR, AMP0..3) to the command-generation stage through a valid/ready handshake, and drives FIFO_FULL back to the NI host.

Parameters:
- DEPTH, 4, frame FIFO depth in frames; power of 2, at least 2.
- TIMEOUT, 255, CLK cycles with no NI byte strobe mid-frame before the parser aborts the frame.
- SYNC_BYTE, 8'hA5, frame header value.

Ports:
- CLK  in  1  divided system clock.
- RST  in  1  asynchronous, active-low reset.
- NI_CLK  in  1  NI byte strobe, asynchronous to CLK.
- NI_DATA_READY  in  1  byte qualifier, asynchronous to CLK.
- NI_DIGITAL_IN  in  8  NI data byte.
- FRAME_READY  in  1  downstream accepts the head frame.
- FRAME_VALID  out  1  FIFO non-empty.
- MODE  out  1  head-frame field.
- BIAS_SEL  out  1  head-frame field.
- BIAS_AMP  out  7  head-frame field.
- ADDR  out  5  head-frame field.
- AMP0, AMP1, AMP2, AMP3  out  8 each  head-frame fields.
- FIFO_FULL  out  1  frame count == DEPTH.
- CSUM_ERR_CNT  out  8  saturating count of checksum and timeout errors.
- OVF_CNT  out  8  saturating count of frames dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0; parser in HUNT; FIFO empty; counters 0; synchronisers cleared.
- Input synchronisation:
  - NI_CLK, NI_DATA_READY and NI_DIGITAL_IN each pass through a 2-flop synchroniser.
  - Byte strobe = rising edge of synced NI_CLK (third flop compare) while synced NI_DATA_READY = 1.
  - The byte is taken from the synced data on the strobe cycle.
  - The host holds data stable at least 3 CLK cycles either side of the NI_CLK rise.
- Frame format, 8 bytes:
  - b0 = SYNC_BYTE.
  - b1 = {MODE, BIAS_SEL, 1'b0, ADDR[4:0]}.
  - b2 = {1'b0, BIAS_AMP[6:0]}.
  - b3..b6 = AMP0..AMP3.
  - b7 = b1^b2^b3^b4^b5^b6.
- Parser FSM:
  - HUNT: on a strobe with byte == SYNC_BYTE go to BODY (idx=1, csum=0); any other byte is ignored.
  - BODY: on each strobe store the byte into the shadow register at idx, csum ^= byte, idx++. After the b6 strobe go to CHECK.
  - CHECK: on the b7 strobe compare b7 with csum.
    - Equal: raise push for one cycle.
    - Not equal: CSUM_ERR_CNT++.
    - Either way, return to HUNT.
  - Timeout: a counter clears on every strobe. In BODY or CHECK, reaching TIMEOUT forces HUNT and CSUM_ERR_CNT++.
  - Reserved bit b1[5] and b2[7] are ignored.
- Latency:
  - The push is registered one cycle after the b7 strobe cycle.
  - FRAME_VALID rises on the cycle after the push when the FIFO was empty, i.e. 2 CLK cycles after the b7 strobe.
- FIFO:
  - First-word-fall-through; the outputs reflect the head entry whenever FRAME_VALID = 1.
  - The outputs hold their last value (are not cleared) when the FIFO is empty.
  - Pop happens when FRAME_VALID && FRAME_READY.
  - A push while FIFO_FULL = 1 is dropped (OVF_CNT++), even if a pop occurs in the same cycle.
  - Push and pop in the same cycle with 0 < count < DEPTH leaves count unchanged.
  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Counters saturate at 8'hFF.
- A reset asserted mid-frame or mid-handshake discards the partial frame and all buffered frames immediately (asynchronous).

Decomposition:
- Shared package galvani_pkg:
  - Frame byte indices and FRAME_LEN = 8.
  - SYNC_BYTE default.
  - Packed frame struct (46 bits: mode, bias_sel, bias_amp, addr, amp[4]).
  - Parser state enum {HUNT, BODY, CHECK}.
- One sub-module: frame_fifo (parameterised FWFT FIFO carrying the packed frame struct, with full/empty/count).

Test Plan:
- Single frame: A5,83,40,10,00,FF,01,csum=2D, FRAME_READY=1 -> exactly one FRAME_VALID pulse, 2 cycles after the b7 strobe, with MODE=1, BIAS_SEL=0, ADDR=3, BIAS_AMP=40, AMP0..3=10,00,FF,01.
- Bad checksum (b7=2C) -> no FRAME_VALID, CSUM_ERR_CNT=1, and the next good frame is accepted.
- Garbage 00,12 before A5, then a good frame -> garbage ignored, one valid frame, CSUM_ERR_CNT=0.
- Timeout: stop after b4 for 256 cycles -> CSUM_ERR_CNT=1, parser back in HUNT, next frame accepted.
- Back-pressure: FRAME_READY=0, DEPTH=4, send 5 good frames -> FIFO_FULL=1 after the 4th, OVF_CNT=1; then raise FRAME_READY -> frames 1..4 emerge in order.
- Reset asserted after b3 -> all outputs 0 asynchronously; the following complete frame is decoded correctly.
